// File: rtl/regfile_pkg.sv
// Shared constants for the register-file write-back path.
//   NUM_REQ  : default number of write-back requesters
//   DATA_W   : register data width
//   ADDR_W   : register index width
//   NUM_REGS : architectural register count (scoreboard width)
//   REG_ZERO : hard-wired zero register index
package regfile_pkg;

  localparam int unsigned NUM_REQ  = 3;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  // Pointer width that stays legal for a single requester.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first asserted request at or above ptr_i, wrapping modulo NUM_REQ.
//   req_i    : request vector
//   ptr_i    : search start index (0..NUM_REQ-1)
//   grant_o  : one-hot grant, zero when no request
//   winner_o : index of the granted requester (0 when none)
//   valid_o  : at least one request present
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = regfile_pkg::NUM_REQ,
  parameter int unsigned PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PTR_W-1:0]   winner_o,
  output logic               valid_o
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant_o  = '0;
    winner_o = '0;
    valid_o  = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      // One extra bit holds ptr+off before the modulo wrap (sum < 2*NUM_REQ).
      sum = {1'b0, ptr_i} + (PTR_W + 1)'(off);
      if (sum >= (PTR_W + 1)'(NUM_REQ)) begin
        sum = sum - (PTR_W + 1)'(NUM_REQ);
      end
      idx = sum[PTR_W-1:0];
      if (!valid_o && req_i[idx]) begin
        valid_o       = 1'b1;
        grant_o[idx]  = 1'b1;
        winner_o      = idx;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the shared register-file write port, plus the
// RAW-hazard pending scoreboard.
//   clock, ctrl_reset_n : clock, async active-low reset
//   ctrl_stall          : suppresses all grants
//   req_valid/req_ready : per-requester handshake (ready is combinational)
//   req_reg/req_data    : packed per-requester destination and data
//   mark_valid/mark_reg : issue-time destination marking
//   pending             : outstanding-write scoreboard, bit 0 always 0
//   ctrl_writeEnable, ctrl_writeReg, data_writeReg, wb_grant : registered write port
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = regfile_pkg::NUM_REQ,
  parameter int unsigned DATA_W  = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W  = regfile_pkg::ADDR_W
) (
  input  logic                        clock,
  input  logic                        ctrl_reset_n,
  input  logic                        ctrl_stall,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_reg,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic                        mark_valid,
  input  logic [ADDR_W-1:0]           mark_reg,
  output logic [NUM_REGS-1:0]         pending,
  output logic                        ctrl_writeEnable,
  output logic [ADDR_W-1:0]           ctrl_writeReg,
  output logic [DATA_W-1:0]           data_writeReg,
  output logic [NUM_REQ-1:0]          wb_grant
);

  localparam int unsigned PTR_W = ptr_width(NUM_REQ);

  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   wreg_q, wreg_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;

  logic [NUM_REQ-1:0]  arb_grant;
  logic [PTR_W-1:0]    arb_winner;
  logic                arb_valid;
  logic                accept;
  logic [ADDR_W-1:0]   sel_reg;
  logic [DATA_W-1:0]   sel_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req_i    (req_valid),
    .ptr_i    (rr_ptr_q),
    .grant_o  (arb_grant),
    .winner_o (arb_winner),
    .valid_o  (arb_valid)
  );

  always_comb begin
    accept    = arb_valid && !ctrl_stall && ctrl_reset_n;
    req_ready = accept ? arb_grant : '0;
    sel_reg   = req_reg[int'(arb_winner) * ADDR_W +: ADDR_W];
    sel_data  = req_data[int'(arb_winner) * DATA_W +: DATA_W];
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    we_d     = 1'b0;
    wreg_d   = wreg_q;
    wdata_d  = wdata_q;
    grant_d  = '0;
    if (accept) begin
      rr_ptr_d = (arb_winner == PTR_W'(NUM_REQ - 1)) ? '0 : arb_winner + 1'b1;
      we_d     = (sel_reg != REG_ZERO);
      wreg_d   = sel_reg;
      wdata_d  = sel_data;
      grant_d  = arb_grant;
    end
  end

  // Clear first, then set: a newer producer issued in the same cycle wins.
  always_comb begin
    pending_d = pending_q;
    if (accept) begin
      pending_d[sel_reg] = 1'b0;
    end
    if (mark_valid && (mark_reg != REG_ZERO)) begin
      pending_d[mark_reg] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      rr_ptr_q  <= '0;
      pending_q <= '0;
      we_q      <= 1'b0;
      wreg_q    <= '0;
      wdata_q   <= '0;
      grant_q   <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      pending_q <= pending_d;
      we_q      <= we_d;
      wreg_q    <= wreg_d;
      wdata_q   <= wdata_d;
      grant_q   <= grant_d;
    end
  end

  assign pending          = pending_q;
  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;
  assign wb_grant         = grant_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic            clock;
  logic            ctrl_reset_n;
  logic            ctrl_stall;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*AW-1:0] req_reg;
  logic [NR*DW-1:0] req_data;
  logic            mark_valid;
  logic [AW-1:0]   mark_reg;
  logic [31:0]     pending;
  logic            ctrl_writeEnable;
  logic [AW-1:0]   ctrl_writeReg;
  logic [DW-1:0]   data_writeReg;
  logic [NR-1:0]   wb_grant;

  int checks = 0;
  int passed = 0;

  // Register file model: captures on the falling edge inside the write cycle.
  logic [DW-1:0] rf [32];

  regfile_wb_arbiter #(
    .NUM_REQ (NR),
    .DATA_W  (DW),
    .ADDR_W  (AW)
  ) dut (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .ctrl_stall       (ctrl_stall),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_reg          (req_reg),
    .req_data         (req_data),
    .mark_valid       (mark_valid),
    .mark_reg         (mark_reg),
    .pending          (pending),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .wb_grant         (wb_grant)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
  end

  always @(negedge clock) begin
    if (ctrl_writeEnable && ctrl_writeReg != '0) rf[ctrl_writeReg] <= data_writeReg;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_port(input string tag, input logic we, input logic [AW-1:0] wr,
                            input logic [DW-1:0] wd, input logic [NR-1:0] gr);
    check({tag, ".we"}, 64'(ctrl_writeEnable), 64'(we));
    check({tag, ".wreg"}, 64'(ctrl_writeReg), 64'(wr));
    check({tag, ".wdata"}, 64'(data_writeReg), 64'(wd));
    check({tag, ".grant"}, 64'(wb_grant), 64'(gr));
  endtask

  initial begin
    ctrl_reset_n = 1'b0;
    ctrl_stall   = 1'b0;
    req_valid    = 3'b111;
    req_reg      = '0;
    req_data     = '0;
    mark_valid   = 1'b0;
    mark_reg     = '0;

    // Reset values
    #2;
    check_port("reset", 1'b0, 5'd0, 32'h0, 3'b000);
    check("reset.pending", 64'(pending), 64'h0);
    check("reset.ready", 64'(req_ready), 64'h0);
    #10;
    ctrl_reset_n = 1'b1;
    req_valid    = 3'b000;
    tick();

    // Single request from requester 0
    req_valid           = 3'b001;
    req_reg[0*AW +: AW] = 5'd5;
    req_data[0*DW +: DW] = 32'hDEADBEEF;
    #1;
    check("single.ready", 64'(req_ready), 64'b001);
    tick();
    req_valid = 3'b000;
    check_port("single", 1'b1, 5'd5, 32'hDEADBEEF, 3'b001);
    @(negedge clock);
    #1;
    check("single.rf5", 64'(rf[5]), 64'hDEADBEEF);
    tick();
    check_port("idle", 1'b0, 5'd5, 32'hDEADBEEF, 3'b000);

    // Stall with requesters 0 and 1 valid; pointer sits at 1
    ctrl_stall          = 1'b1;
    req_valid           = 3'b011;
    req_reg[1*AW +: AW] = 5'd10;
    req_data[1*DW +: DW] = 32'h0000_0A0A;
    mark_valid          = 1'b1;
    mark_reg            = 5'd7;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall.ready", 64'(req_ready), 64'h0);
      tick();
      mark_valid = 1'b0;
      check("stall.we", 64'(ctrl_writeEnable), 64'h0);
    end
    check("mark7.pending", 64'(pending), 64'h0000_0080);
    ctrl_stall = 1'b0;
    #1;
    check("release.ready", 64'(req_ready), 64'b010);
    tick();
    req_valid = 3'b000;
    check_port("release", 1'b1, 5'd10, 32'h0000_0A0A, 3'b010);
    check("release.pending", 64'(pending), 64'h0000_0080);

    // Requester 2 writes register 7, clearing its pending bit
    req_valid            = 3'b100;
    req_reg[2*AW +: AW]  = 5'd7;
    req_data[2*DW +: DW] = 32'h0000_0077;
    tick();
    req_valid = 3'b000;
    check_port("sb_clear", 1'b1, 5'd7, 32'h0000_0077, 3'b100);
    check("sb_clear.pending", 64'(pending), 64'h0);

    // Fairness: all three continuously valid, pointer back at 0
    req_reg  = {5'd3, 5'd2, 5'd1};
    req_data = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
    req_valid = 3'b111;
    begin
      logic [NR-1:0] exp_g;
      logic [AW-1:0] exp_r;
      for (int i = 0; i < 6; i++) begin
        tick();
        exp_g = 3'b001 << (i % 3);
        exp_r = AW'(i % 3 + 1);
        check("rr.grant", 64'(wb_grant), 64'(exp_g));
        check("rr.wreg", 64'(ctrl_writeReg), 64'(exp_r));
      end
    end
    req_valid = 3'b000;
    tick();
    check("rr.drain_we", 64'(ctrl_writeEnable), 64'h0);

    // Register 0: accepted, consumes grant, never written, never marked
    mark_valid           = 1'b1;
    mark_reg             = 5'd0;
    req_valid            = 3'b001;
    req_reg[0*AW +: AW]  = 5'd0;
    req_data[0*DW +: DW] = 32'h0000_1234;
    #1;
    check("r0.ready", 64'(req_ready), 64'b001);
    tick();
    mark_valid = 1'b0;
    req_valid  = 3'b000;
    check_port("r0", 1'b0, 5'd0, 32'h0000_1234, 3'b001);
    check("r0.pending", 64'(pending), 64'h0);
    @(negedge clock);
    #1;
    check("r0.rf0", 64'(rf[0]), 64'h0);

    // Mark 9, then mark 9 and write 9 together: set wins
    tick();
    mark_valid = 1'b1;
    mark_reg   = 5'd9;
    tick();
    check("mark9.pending", 64'(pending), 64'h0000_0200);
    req_valid            = 3'b010;
    req_reg[1*AW +: AW]  = 5'd9;
    req_data[1*DW +: DW] = 32'h0000_0909;
    tick();
    req_valid = 3'b000;
    check("setclr.pending", 64'(pending), 64'h0000_0200);
    check_port("setclr", 1'b1, 5'd9, 32'h0000_0909, 3'b010);
    mark_reg = 5'd8;
    tick();
    mark_reg = 5'd10;
    tick();
    // Last mark alongside an unmarked write to register 4
    mark_reg             = 5'd11;
    req_valid            = 3'b001;
    req_reg[0*AW +: AW]  = 5'd4;
    req_data[0*DW +: DW] = 32'h0000_0444;
    tick();
    mark_valid = 1'b0;
    req_valid  = 3'b111;
    check("pre_rst.pending", 64'(pending), 64'h0000_0F00);
    check_port("pre_rst", 1'b1, 5'd4, 32'h0000_0444, 3'b001);

    // Asynchronous reset mid-cycle
    #2;
    ctrl_reset_n = 1'b0;
    #1;
    check_port("midrst", 1'b0, 5'd0, 32'h0, 3'b000);
    check("midrst.pending", 64'(pending), 64'h0);
    check("midrst.ready", 64'(req_ready), 64'h0);
    ctrl_reset_n = 1'b1;
    #1;
    check("post_rst.ready", 64'(req_ready), 64'b001);
    tick();
    check("post_rst.grant", 64'(wb_grant), 64'b001);
    req_valid = 3'b000;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single write port of the 32×32 register file between several write-back requesters, such as the ALU, load unit and multiply/divide unit. Each requester uses a valid/ready handshake. A round-robin arbiter grants one requester per cycle and registers the winner onto the register-file write port. A 32-bit pending scoreboard tracks destinations that have been issued but not yet written, so the decode stage can detect RAW hazards.

## Interface
Parameters:
- NUM_REQ, 3: number of write-back requesters.
- DATA_W, 32: register data width.
- ADDR_W, 5: register index width.

Ports:
- clock  in  1  system clock.
- ctrl_reset_n  in  1  reset, asynchronous, active-low.
- ctrl_stall  in  1  freezes arbitration; no grants while high.
- req_valid  in  NUM_REQ  per-requester write request.
- req_ready  out  NUM_REQ  per-requester grant; accept = valid & ready.
- req_reg  in  NUM_REQ*ADDR_W  destination register; requester i uses slice [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  write data; requester i uses slice [i*DATA_W +: DATA_W].
- mark_valid  in  1  an instruction with a destination register issued this cycle.
- mark_reg  in  ADDR_W  destination of the issuing instruction.
- pending  out  32  scoreboard; bit r = 1 means a write to r is outstanding.
- ctrl_writeEnable  out  1  register-file write enable (registered).
- ctrl_writeReg  out  ADDR_W  register-file write index (registered).
- data_writeReg  out  DATA_W  register-file write data (registered).
- wb_grant  out  NUM_REQ  one-hot identity of the requester driving the current write (registered).

## Operation
- **Round-robin pointer.** rr_ptr ranges 0..NUM_REQ-1. Each cycle the winner is the first i with req_valid[i], searching from rr_ptr upward and wrapping modulo NUM_REQ.
- **req_ready.** Combinational; one-hot on the winner, all zero when no request is valid or ctrl_stall=1. req_ready depends on req_valid, so requesters must not make req_valid depend on req_ready.
- **On accept.**
  - rr_ptr <= (winner+1) mod NUM_REQ.
  - Output stage loads req_reg/req_data of the winner.
  - wb_grant <= one-hot(winner).
  - ctrl_writeEnable <= (req_reg != 0).
- **Register 0.** Writes to register 0 are accepted and consume the grant but are never driven: ctrl_writeEnable stays 0.
- **No accept.** ctrl_writeEnable <= 0 and wb_grant <= 0. ctrl_writeReg/data_writeReg hold their previous values and rr_ptr holds.
- **Scoreboard set.** mark_valid with mark_reg != 0 sets pending[mark_reg].
- **Scoreboard clear.** An accept with req_reg = r clears pending[r].
- **Simultaneous set and clear of the same r.** Set wins; a newer producer has issued.
- **pending[0].** Constant 0.
- **Unmarked writes.** An accepted write to a register whose pending bit is 0 is still performed; the scoreboard bit stays 0.
- **Stall.** ctrl_stall=1 blocks only grants. Scoreboard marks still apply, and the output stage drops ctrl_writeEnable to 0 at the next edge.

## Timing
- **Reset values.** ctrl_reset_n low asynchronously forces:
  - pending=0, rr_ptr=0;
  - ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, wb_grant=0;
  - req_ready=0 while reset is asserted.
- **Reset mid-operation.** An in-flight write is discarded, not replayed.
- **Write latency.** A write accepted at rising edge N drives ctrl_writeEnable high from edge N to edge N+1. The register file captures it on the falling edge inside that cycle.
- **Read after write.** A combinational read of the same register returns new data in the second half of cycle N+1.
- **Pending clear.** pending[r] clears at edge N, the same edge ctrl_writeEnable rises. Decode logic that reads the register file in cycle N+1 sees correct data after the falling edge.
- **Throughput.** One write per cycle. With all NUM_REQ requesters continuously valid, each is granted exactly once every NUM_REQ cycles.
- **Pointer wrap.** The rr_ptr increment wraps modulo NUM_REQ; NUM_REQ need not be a power of two.

## Structure
- **Shared package regfile_pkg:** NUM_REQ, DATA_W, ADDR_W, NUM_REGS=32, REG_ZERO=0.
- **Sub-module rr_arbiter:** combinational. Inputs are the request vector and rr_ptr; outputs are the one-hot grant and winner index. It is reusable by other shared-resource controllers.
- **Top level:** holds rr_ptr, the output stage and the scoreboard.

## Test plan
- **Single request.** Reset, then req_valid=3'b001, req_reg[0]=5, req_data[0]=32'hDEADBEEF for 1 cycle → next cycle ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=32'hDEADBEEF, wb_grant=3'b001. Register-file read of 5 returns 32'hDEADBEEF.
- **Round-robin fairness.** All three valid continuously for 6 cycles with destinations 1/2/3 → wb_grant sequence 001,010,100,001,010,100. No requester is granted twice in any 3-cycle window.
- **Register 0 write.** mark_valid with mark_reg=0, then a request to register 0 with data 32'h1234 → accepted (req_ready=1) but ctrl_writeEnable stays 0, pending stays 0, and register 0 still reads 0.
- **Scoreboard.** mark_reg=7 at cycle 1 → pending[7]=1. Requester 2 writes register 7 at cycle 4 → pending[7]=0 after edge 4. Separately, mark register 9 and accept a write to 9 in the same cycle → pending[9] remains 1.
- **Stall.** ctrl_stall=1 for 3 cycles with requester 1 valid → req_ready=0 and ctrl_writeEnable=0 throughout, and rr_ptr is unchanged. On release, requester 1 is granted in the first cycle.
- **Reset mid-operation.** Assert ctrl_reset_n=0 asynchronously between edges while ctrl_writeEnable=1 and pending=32'h0000_0F00 → all outputs zero immediately. After release the first grant goes to requester 0.
